// File: rtl/fp_mul_arbiter_if.sv
// Shared types and the bundled handshake interface for fp_mul_arbiter.
// The package carries the floating-point format selector and the unrounded
// result record that fp_mul hands to the downstream rounding stage.
package fp_mul_arbiter_pkg;

  typedef enum logic [0:0] {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_format_e;

  // Widest supported format; narrower formats use the low bits of u_result.
  localparam int unsigned FP_MAX_W = 32;

  typedef struct packed {
    logic [FP_MAX_W-1:0] u_result;
    logic [1:0]          rs;
    logic                round_en;
    logic                invalid;
  } uround_res_t;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    int unsigned w;
    case (fmt)
      FP32:    w = 32;
      FP16:    w = 16;
      default: w = 32;
    endcase
    return w;
  endfunction

endpackage

// Request, response and fp_mul-side signals of the arbiter in one bundle.
// The slave modport is the arbiter; the master modport is its environment.
interface fp_mul_arbiter_if
  import fp_mul_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned FP_WIDTH = 32
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]               req_valid_i;
  logic [NUM_REQ-1:0]               req_ready_o;
  logic [NUM_REQ-1:0][FP_WIDTH-1:0] req_a_i;
  logic [NUM_REQ-1:0][FP_WIDTH-1:0] req_b_i;
  logic                             resp_valid_o;
  logic                             resp_ready_i;
  logic [ID_W-1:0]                  resp_id_o;
  uround_res_t                      resp_result_o;
  logic                             resp_timeout_o;
  logic [FP_WIDTH-1:0]              mul_a_o;
  logic [FP_WIDTH-1:0]              mul_b_o;
  logic                             mul_start_o;
  logic                             mul_done_i;
  uround_res_t                      mul_result_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, resp_ready_i, mul_done_i, mul_result_i,
    output req_ready_o, resp_valid_o, resp_id_o, resp_result_o, resp_timeout_o,
           mul_a_o, mul_b_o, mul_start_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, resp_ready_i, mul_done_i, mul_result_i,
    input  req_ready_o, resp_valid_o, resp_id_o, resp_result_o, resp_timeout_o,
           mul_a_o, mul_b_o, mul_start_o
  );

endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin controller sharing one fp_mul datapath among NUM_REQ requesters.
// One operation is in flight at a time: IDLE grants, BUSY runs fp_mul,
// RESP holds the registered unrounded result until downstream accepts it.
// Optional watchdog: define FP_MUL_ARB_TIMEOUT_EN to abort a BUSY phase that
// sees no done within TIMEOUT_CYCLES cycles.
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT      = FP32,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  fp_mul_arbiter_if.slave      bus
);

  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT);
  localparam int unsigned ID_W     = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_next_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [ID_W-1:0]     grant_id_s;
  logic                grant_found_s;
  logic [ID_W-1:0]     cand_s;
  logic                handshake_s;
  logic                expire_s;
  logic [FP_WIDTH-1:0] op_a_r;
  logic [FP_WIDTH-1:0] op_b_r;
  logic [ID_W-1:0]     cur_id_r;
  logic [ID_W-1:0]     last_grant_r;
  uround_res_t         result_r;
  logic                timeout_r;

  // Rotating priority search starting just above the last grant.
  always_comb begin
    grant_s       = '0;
    grant_id_s    = '0;
    grant_found_s = 1'b0;
    cand_s        = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand_s = ID_W'((int'(last_grant_r) + 1 + k) % int'(NUM_REQ));
      if (!grant_found_s && bus.req_valid_i[cand_s]) begin
        grant_found_s = 1'b1;
        grant_id_s    = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
    if (grant_found_s) begin
      grant_s[grant_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign handshake_s = (state_r == ST_IDLE) && grant_found_s;

`ifdef FP_MUL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_r;

  // Watchdog: held at zero outside BUSY, counts BUSY cycles without done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_r <= '0;
    end else if (state_r != ST_BUSY) begin
      tmo_cnt_r <= '0;
    end else if (!bus.mul_done_i) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // A done in the expiry cycle wins, so expiry requires done to be low.
  assign expire_s = (state_r == ST_BUSY) && !bus.mul_done_i &&
                    (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; done and resp_ready only steer the next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_found_s) state_next_s = ST_BUSY;
        else               state_next_s = ST_IDLE;
      end
      ST_BUSY: begin
        if (bus.mul_done_i || expire_s) state_next_s = ST_RESP;
        else                            state_next_s = ST_BUSY;
      end
      ST_RESP: begin
        if (bus.resp_ready_i) state_next_s = ST_IDLE;
        else                  state_next_s = ST_RESP;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Latch the granted operands and owner on the request handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_r       <= '0;
      op_b_r       <= '0;
      cur_id_r     <= '0;
      last_grant_r <= ID_W'(NUM_REQ - 1);
    end else if (handshake_s) begin
      op_a_r       <= bus.req_a_i[grant_id_s];
      op_b_r       <= bus.req_b_i[grant_id_s];
      cur_id_r     <= grant_id_s;
      last_grant_r <= grant_id_s;
    end else begin
      op_a_r       <= op_a_r;
      op_b_r       <= op_b_r;
      cur_id_r     <= cur_id_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Capture the fp_mul result on done, or an invalid record on watchdog expiry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_r  <= '0;
      timeout_r <= 1'b0;
    end else if ((state_r == ST_BUSY) && bus.mul_done_i) begin
      result_r  <= bus.mul_result_i;
      timeout_r <= 1'b0;
    end else if (expire_s) begin
      result_r  <= '{u_result: {FP_MAX_W{1'b0}}, rs: 2'b00, round_en: 1'b0, invalid: 1'b1};
      timeout_r <= 1'b1;
    end else begin
      result_r  <= result_r;
      timeout_r <= timeout_r;
    end
  end

  assign bus.req_ready_o    = (state_r == ST_IDLE) ? grant_s : {NUM_REQ{1'b0}};
  assign bus.mul_start_o    = (state_r == ST_BUSY);
  assign bus.mul_a_o        = op_a_r;
  assign bus.mul_b_o        = op_b_r;
  assign bus.resp_valid_o   = (state_r == ST_RESP);
  assign bus.resp_id_o      = cur_id_r;
  assign bus.resp_result_o  = result_r;
`ifdef FP_MUL_ARB_TIMEOUT_EN
  assign bus.resp_timeout_o = timeout_r;
`else
  assign bus.resp_timeout_o = 1'b0;
`endif

endmodule
